leakyrelu_stream_rx: RTL
========================

// Module: leakyrelu_stream_rx
// PURPOSE
//  Receive end of the 64-bit layer-2 LeakyReLU stream (valid/ready/last, 8 bytes per beat, byte0 = data[7:0]).
//  Captures one frame of BEATS beats into an internal buffer and checks framing.
//  Provides a byte-addressed read port for the downstream layer and for bench comparison against the reference txt.
// PARAMETERS
//  BEATS      32   beats per frame; last is required on beat BEATS-1
//  DATA_W     64   stream width; fixed at 8 bytes/beat
//  ADDR_W     8    byte address width; equals log2(BEATS*8)
// PORTS
//  sclk            in   1       clock
//  s_rst_n         in   1       async active-low reset
//  s_data          in   64      stream data
//  s_valid         in   1       stream valid
//  s_last          in   1       stream last
//  s_ready         out  1       stream ready
//  clr             in   1       1-cycle pulse: rearm for a new frame
//  rd_en           in   1       byte read request
//  rd_addr         in   ADDR_W  byte address
//  rd_data         out  8       read data, valid 1 cycle after rd_en
//  frame_done      out  1       frame closed (good or bad)
//  err_last_early  out  1       last seen on beat < BEATS-1
//  err_last_miss   out  1       beat BEATS-1 accepted without last
//  beat_cnt        out  6       beats accepted in the current frame
// BEHAVIOUR
//  - Reset is s_rst_n, asynchronous, active-low; clock is sclk.
//  - Reset values: state=RECV, beat_cnt=0, frame_done=0, both err=0, rd_data=0, LFSR=8'hA5.
//  - s_ready is combinational: (state==RECV) & thr_ok. It is 0 while reset is asserted.
//  - Accept = s_valid & s_ready. On accept, write the s_data word to buffer word beat_cnt, then beat_cnt+1.
//  - FSM RECV -> DONE on the first accept that meets either condition:
//      a) s_last=1 with beat_cnt<BEATS-1: set err_last_early.
//      b) beat_cnt==BEATS-1 (the last beat): set err_last_miss if s_last=0.
//    A good frame is s_last=1 exactly on beat BEATS-1; it sets no error.
//  - DONE: s_ready=0, frame_done=1, errors and beat_cnt held. Buffer keeps its contents.
//  - clr in DONE: next cycle state=RECV, beat_cnt=0, frame_done=0, errors=0. Buffer is not cleared.
//  - clr in RECV: restarts the frame; beat_cnt=0. clr has priority over a same-cycle accept, which is discarded.
//  - s_valid=0 in RECV: no state change. Data and last are don't-care unless accepted.
//  - Read: rd_data is registered 1 cycle after rd_en, taken from word rd_addr[7:3], byte rd_addr[2:0].
//    Without rd_en, rd_data holds its value.
//  - Same-cycle read and write of the same word returns the old word (read-first).
//  - Reset mid-frame: all control state returns to reset values; buffer contents are undefined.
// CONFIGURATION
//  RX_THROTTLE_EN defined:
//    - 8-bit Fibonacci LFSR, taps 8,6,5,4, seed 8'hA5, advances every cycle.
//    - thr_ok = |lfsr[1:0], giving about 75% ready duty. This exercises transmitter backpressure.
//  RX_THROTTLE_EN undefined: thr_ok=1 and no LFSR is instantiated.
// STRUCTURE
//  Package leakyrelu_stream_pkg:
//    - BEATS_DEF, BYTES_PER_BEAT=8
//    - state encoding RECV=1'b0, DONE=1'b1
//    - LFSR_SEED=8'hA5, LFSR_TAPS
//  Sub-module rx_beat_ram: BEATS x 64 synchronous RAM, 1 write port, 1 registered read port, read-first.
//  Top level holds the FSM, counter, error flags, optional LFSR and the byte mux on the RAM output.
// TESTING
//  T1 good frame, throttle off, s_valid=1 for 32 beats, beat k = {8{k[7:0]}}, last on beat 31:
//     - s_ready=1 throughout; frame_done=1 the cycle after beat 31; beat_cnt=32; no errors.
//     - rd_addr=8'h0F returns 8'h01.
//  T2 early last on beat 5: err_last_early=1, frame_done=1, beat_cnt=6, s_ready=0; later beats are not accepted.
//  T3 no last on beat 31: err_last_miss=1, beat_cnt=32, frame_done=1.
//  T4 clr after T2, then T1 stream: errors cleared, good frame; buffer words 0..31 are overwritten.
//  T5 RX_THROTTLE_EN, s_valid held 1:
//     - s_ready follows the LFSR pattern; first low cycle predicted from seed 8'hA5.
//     - All 32 beats land at the correct address; data matches the txt file byte-for-byte.
//  T6 s_rst_n low at beat 10, then released:
//     - s_ready=0 during reset; beat_cnt=0 afterwards.
//     - A fresh full frame completes with no errors.

Source files
------------

// File: rtl/leakyrelu_stream_pkg.sv
// Shared types and constants for the layer-2 LeakyReLU stream receiver.
package leakyrelu_stream_pkg;
  localparam int BEATS_DEF      = 32;
  localparam int BYTES_PER_BEAT = 8;

  typedef enum logic {RECV = 1'b0, DONE = 1'b1} rx_state_t;

  typedef struct packed {
    logic [5:0] beat_cnt;
    logic       err_early;
    logic       err_miss;
  } rx_ctl_t;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;  // taps 8,6,5,4

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/leakyrelu_stream_rx_beat_ram.sv
// BEATS x 64 beat buffer: one write port, one registered read-first read port, split into byte lanes.
module rx_beat_ram
  import leakyrelu_stream_pkg::*;
#(
  parameter int DEPTH = BEATS_DEF,
  parameter int LANES = BYTES_PER_BEAT,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                  sclk,
  input  logic                  s_rst_n,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [LANES-1:0][7:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [LANES-1:0][7:0] rdata
);
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] q;

    always_ff @(posedge sclk)
      if (we) mem[waddr] <= wdata[l];

    // Non-blocking read of mem gives the pre-write word on a same-cycle collision.
    always_ff @(posedge sclk or negedge s_rst_n)
      if (!s_rst_n) q <= '0;
      else if (re)  q <= mem[raddr];

    assign rdata[l] = q;
  end
endmodule

// File: rtl/leakyrelu_stream_rx.sv
// Receive end of the LeakyReLU stream: frame capture, framing checks, byte read port.
// Define RX_THROTTLE_EN to throttle s_ready with an 8-bit LFSR (about 75% duty).
module leakyrelu_stream_rx
  import leakyrelu_stream_pkg::*;
#(
  parameter int BEATS  = BEATS_DEF,
  parameter int DATA_W = 64,
  parameter int ADDR_W = 8
) (
  input  logic              sclk,
  input  logic              s_rst_n,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  input  logic              clr,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              frame_done,
  output logic              err_last_early,
  output logic              err_last_miss,
  output logic [5:0]        beat_cnt
);
  localparam int         WA        = ADDR_W - 3;
  localparam logic [5:0] LAST_BEAT = 6'(BEATS - 1);

  rx_state_t state, state_n;
  rx_ctl_t   ctl, ctl_n;
  logic      thr_ok, accept, wr_en;
  logic [2:0] sel_q;
  logic [BYTES_PER_BEAT-1:0][7:0] wword, rword;

`ifdef RX_THROTTLE_EN
  logic [7:0] lfsr;
  always_ff @(posedge sclk or negedge s_rst_n)
    if (!s_rst_n) lfsr <= LFSR_SEED;
    else          lfsr <= lfsr_next(lfsr);
  assign thr_ok = |lfsr[1:0];
`else
  assign thr_ok = 1'b1;
`endif

  // Gated with reset so the transmitter never sees ready while we are held in reset.
  assign s_ready = s_rst_n & (state == RECV) & thr_ok;
  assign accept  = s_valid & s_ready;
  assign wr_en   = accept & ~clr;

  always_ff @(posedge sclk or negedge s_rst_n)
    if (!s_rst_n) begin
      state <= RECV;
      ctl   <= '0;
    end else begin
      state <= state_n;
      ctl   <= ctl_n;
    end

  always_comb begin
    state_n = state;
    ctl_n   = ctl;
    case (state)
      RECV:
        if (clr) ctl_n = '0;
        else if (accept) begin
          ctl_n.beat_cnt = ctl.beat_cnt + 6'd1;
          if (s_last && ctl.beat_cnt < LAST_BEAT) begin
            state_n         = DONE;
            ctl_n.err_early = 1'b1;
          end else if (ctl.beat_cnt == LAST_BEAT) begin
            state_n        = DONE;
            ctl_n.err_miss = ~s_last;
          end
        end
      DONE:
        if (clr) begin
          state_n = RECV;
          ctl_n   = '0;
        end
      default: state_n = RECV;
    endcase
  end

  assign frame_done     = (state == DONE);
  assign err_last_early = ctl.err_early;
  assign err_last_miss  = ctl.err_miss;
  assign beat_cnt       = ctl.beat_cnt;

  assign wword = s_data;

  rx_beat_ram #(.DEPTH(BEATS), .LANES(BYTES_PER_BEAT), .AW(WA)) u_ram (
    .sclk   (sclk),
    .s_rst_n(s_rst_n),
    .we     (wr_en),
    .waddr  (ctl.beat_cnt[WA-1:0]),
    .wdata  (wword),
    .re     (rd_en),
    .raddr  (rd_addr[ADDR_W-1:3]),
    .rdata  (rword)
  );

  // Byte select registered alongside the RAM word so rd_data holds without rd_en.
  always_ff @(posedge sclk or negedge s_rst_n)
    if (!s_rst_n)   sel_q <= '0;
    else if (rd_en) sel_q <= rd_addr[2:0];

  assign rd_data = rword[sel_q];
endmodule
